// File: rtl/aud_pkg.sv
// Shared types and constants for the stereo DAC player.
package aud_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DELAY,
      S_SHIFT,
      S_PAD
   } aud_play_state_e;

   localparam logic AUD_FMT_I2S = 1'b0;
   localparam logic AUD_FMT_LJ  = 1'b1;

endpackage

// File: rtl/aud_shift_tx.sv
// Parallel-load MSB-first shifter with a down-counting bit counter.
// Load together with shift loads the word already advanced by one bit.
module aud_shift_tx #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_msb,
   output logic [CNT_W-1:0]  o_cnt
);

   logic [DATA_W-1:0] sr_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (i_clear) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (i_load) begin
         if (i_shift) begin
            sr_q  <= {i_data[DATA_W-2:0], 1'b0};
            cnt_q <= CNT_W'(DATA_W - 1);
         end else begin
            sr_q  <= i_data;
            cnt_q <= CNT_W'(DATA_W);
         end
      end else if (i_shift) begin
         sr_q <= {sr_q[DATA_W-2:0], 1'b0};
         // Saturate at zero so the count never wraps
         if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign o_msb = sr_q[DATA_W-1];
   assign o_cnt = cnt_q;

endmodule

// File: rtl/aud_player_stereo.sv
// Stereo DAC serializer: frames a latched L/R pair onto DACDAT using DACLRCK,
// with I2S or left-justified timing, mono duplicate and underrun reporting.
module aud_player_stereo
   import aud_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_daclrck,
   input  logic              i_left_justify,
   input  logic              i_mono,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_left_data,
   input  logic [DATA_W-1:0] i_right_data,
   output logic              o_ack,
   output logic              o_underrun,
   output logic              o_busy,
   output logic              o_aud_dacdat
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   aud_play_state_e   state_q, state_d;
   logic              lrck_q, lj_q, chan_r_q;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic              edge_c, start_l_c, start_r_c, fmt_c;
   logic [DATA_W-1:0] pair_l_c, pair_r_c, word_c;
   logic              ld_c, sh_c, clr_c, dat_d, ack_d, und_d;
   logic              sr_msb;
   logic [CNT_W-1:0]  cnt;

   assign edge_c    = i_daclrck ^ lrck_q;
   assign start_l_c = i_en && edge_c && !i_daclrck && (state_q != S_IDLE);
   assign start_r_c = i_en && edge_c && i_daclrck &&
                      (state_q inside {S_DELAY, S_SHIFT, S_PAD});
   assign pair_l_c  = i_valid ? i_left_data : '0;
   assign pair_r_c  = i_valid ? (i_mono ? i_left_data : i_right_data) : '0;
   assign fmt_c     = start_l_c ? i_left_justify : lj_q;
   assign clr_c     = !i_en;

   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Framing FSM: a start edge always wins over the current slot's progress
   always_comb begin
      state_d = state_q;
      ld_c    = 1'b0;
      sh_c    = 1'b0;
      dat_d   = 1'b0;
      ack_d   = 1'b0;
      und_d   = 1'b0;
      word_c  = hold_r;
      if (!i_en) begin
         state_d = S_IDLE;
      end else if (start_l_c || start_r_c) begin
         ack_d = start_l_c && i_valid;
         und_d = start_l_c && !i_valid;
         if (fmt_c == AUD_FMT_LJ) begin
            ld_c    = 1'b1;
            sh_c    = 1'b1;
            word_c  = start_l_c ? pair_l_c : hold_r;
            dat_d   = word_c[DATA_W-1];
            state_d = S_SHIFT;
         end else begin
            state_d = S_DELAY;
         end
      end else begin
         case (state_q)
            S_IDLE: state_d = S_SYNC;
            S_DELAY: begin
               ld_c    = 1'b1;
               sh_c    = 1'b1;
               word_c  = chan_r_q ? hold_r : hold_l;
               dat_d   = word_c[DATA_W-1];
               state_d = S_SHIFT;
            end
            S_SHIFT: begin
               sh_c  = 1'b1;
               dat_d = sr_msb;
               if (cnt <= CNT_W'(1)) state_d = S_PAD;
            end
            S_SYNC, S_PAD: state_d = state_q;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lrck_q       <= 1'b1;
         lj_q         <= AUD_FMT_I2S;
         chan_r_q     <= 1'b0;
         hold_l       <= '0;
         hold_r       <= '0;
         o_ack        <= 1'b0;
         o_underrun   <= 1'b0;
         o_busy       <= 1'b0;
         o_aud_dacdat <= 1'b0;
      end else begin
         lrck_q       <= i_daclrck;
         o_ack        <= ack_d;
         o_underrun   <= und_d;
         o_busy       <= !(state_d inside {S_IDLE, S_SYNC});
         o_aud_dacdat <= dat_d;
         if (start_l_c) begin
            hold_l <= pair_l_c;
            hold_r <= pair_r_c;
            lj_q   <= i_left_justify;
         end
         if (start_l_c || start_r_c) chan_r_q <= start_r_c;
      end
   end

   aud_shift_tx #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shift (
      .i_bclk  (i_bclk),
      .i_rst_n (i_rst_n),
      .i_clear (clr_c),
      .i_load  (ld_c),
      .i_shift (sh_c),
      .i_data  (word_c),
      .o_msb   (sr_msb),
      .o_cnt   (cnt)
   );

endmodule
